// File: rtl/fpmult_share_arbiter_if.sv
// fpmult_share_arbiter_if: requester, multiplier and response signals around the shared FP multiplier arbiter
interface fpmult_share_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic               mul_valid;
    logic [31:0]        mul_a;
    logic [31:0]        mul_b;
    logic [31:0]        mul_p;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*32-1:0] rsp_data;
    logic [NREQ-1:0]    rsp_ready;

    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_data
    );
endinterface

// File: rtl/fpmult_share_arbiter.sv
// fpmult_share_arbiter: round-robin sharing of one pipelined FP multiplier with tagged result return
module fpmult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input logic                   clk,
    input logic                   rst_n,
    fpmult_share_arbiter_if.slave bus
);
    logic [NREQ-1:0]    busy_q, busy_d, elig, grant;
    logic [IDXW-1:0]    rr_ptr_q, rr_ptr_d, cand, gnt_idx, iss_idx_q;
    logic               gnt_vld, iss_vld_q;
    logic [31:0]        iss_a_q, iss_b_q;
    logic [LAT-1:0]     tag_vld_q;
    logic [IDXW-1:0]    tag_idx_q [LAT];
    logic [NREQ-1:0]    rsp_vld_q;
    logic [NREQ*32-1:0] rsp_dat_q;

    assign elig = bus.req_valid & ~busy_q;

    // First eligible requester at or after rr_ptr wins; busy is set on grant and dropped on result accept
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int j = 0; j < NREQ; j++) begin
            cand = IDXW'((int'(rr_ptr_q) + j) % NREQ);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        grant    = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
        busy_d   = (busy_q | grant) & ~(rsp_vld_q & bus.rsp_ready);
        rr_ptr_d = !gnt_vld ? rr_ptr_q : (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + IDXW'(1);
    end

    // Arbiter state and the registered issue stage feeding the multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            rr_ptr_q  <= '0;
            iss_vld_q <= 1'b0;
            iss_idx_q <= '0;
            iss_a_q   <= '0;
            iss_b_q   <= '0;
        end else begin
            busy_q    <= busy_d;
            rr_ptr_q  <= rr_ptr_d;
            iss_vld_q <= gnt_vld;
            if (gnt_vld) begin
                iss_idx_q <= gnt_idx;
                iss_a_q   <= bus.req_a[{gnt_idx, 5'd0} +: 32];
                iss_b_q   <= bus.req_b[{gnt_idx, 5'd0} +: 32];
            end
        end
    end

    // Tag pipe: the last stage lines up with the product leaving the multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            for (int s = 0; s < LAT; s++) tag_idx_q[s] <= '0;
        end else begin
            tag_vld_q[0] <= iss_vld_q;
            tag_idx_q[0] <= iss_idx_q;
            for (int s = 1; s < LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end

    // Result slots: capture the tagged product, hold it until the owner accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_q & ~bus.rsp_ready;
            if (tag_vld_q[LAT-1]) begin
                rsp_vld_q[tag_idx_q[LAT-1]]             <= 1'b1;
                rsp_dat_q[{tag_idx_q[LAT-1], 5'd0} +: 32] <= bus.mul_p;
            end
        end
    end

    assign bus.req_ready = rst_n ? grant : '0;
    assign bus.mul_valid = iss_vld_q;
    assign bus.mul_a     = iss_a_q;
    assign bus.mul_b     = iss_b_q;
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_data  = rsp_dat_q;
endmodule

// File: tb/tb_fpmult_share_arbiter.sv
// tb_fpmult_share_arbiter: directed and randomized checks of the shared FP multiplier arbiter against a completion-queue model
module tb_fpmult_share_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam logic [31:0] ONE = 32'h3F80_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fpmult_share_arbiter_if #(.NREQ(NREQ)) bus ();
    fpmult_share_arbiter_if #(.NREQ(2))    bus2 ();

    fpmult_share_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDXW(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    fpmult_share_arbiter #(.NREQ(2),    .LAT(1),   .IDXW(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Mock multiplier: adds the biased exponent fields, which is an exact product for 2.0*3.0 = 6.0
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return a + b - ONE;
    endfunction

    // Mock pipelines never reset, so stale products keep arriving after a DUT reset
    logic [31:0] junk = 32'h0;
    logic        mp_v [LAT];
    logic [31:0] mp_d [LAT];
    logic        mp2_v = 1'b0;
    logic [31:0] mp2_d = 32'h0;
    always @(posedge clk) begin
        junk     <= $urandom;
        mp_v[0]  <= bus.mul_valid;
        mp_d[0]  <= fmul(bus.mul_a, bus.mul_b);
        for (int s = 1; s < LAT; s++) begin
            mp_v[s] <= mp_v[s-1];
            mp_d[s] <= mp_d[s-1];
        end
        mp2_v <= bus2.mul_valid;
        mp2_d <= fmul(bus2.mul_a, bus2.mul_b);
    end
    assign bus.mul_p  = (mp_v[LAT-1] === 1'b1) ? mp_d[LAT-1] : junk;
    assign bus2.mul_p = mp2_v ? mp2_d : ~junk;

    // Reference model: grant rule, busy flags and a queue of results due at a given edge
    typedef struct { int due; int idx; logic [31:0] d; } op_t;
    op_t             pend[$];
    int              cyc = 0;
    int              m_rr;
    logic [NREQ-1:0] m_busy, m_rv;
    logic [31:0]     m_rd [NREQ];
    logic            m_mv;
    logic [31:0]     m_ma, m_mb;

    task automatic model_clear();
        pend.delete();
        m_rr = 0; m_busy = '0; m_rv = '0; m_mv = 1'b0; m_ma = '0; m_mb = '0;
        for (int i = 0; i < NREQ; i++) m_rd[i] = '0;
    endtask

    function automatic int exp_grant();
        for (int j = 0; j < NREQ; j++) begin
            int k = (m_rr + j) % NREQ;
            if (bus.req_valid[k] && !m_busy[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g = exp_grant();
        return (g < 0) ? '0 : NREQ'(1) << g;
    endfunction

    function automatic logic [NREQ*32-1:0] exp_data();
        logic [NREQ*32-1:0] v;
        for (int i = 0; i < NREQ; i++) v[32*i +: 32] = m_rd[i];
        return v;
    endfunction

    task automatic tick();
        int  g;
        op_t o;
        g = exp_grant();
        @(posedge clk);
        cyc++;
        m_busy &= ~(m_rv & bus.rsp_ready);
        m_rv   &= ~bus.rsp_ready;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            m_rv[pend[0].idx] = 1'b1;
            m_rd[pend[0].idx] = pend[0].d;
            void'(pend.pop_front());
        end
        m_mv = (g >= 0);
        if (g >= 0) begin
            m_busy[g] = 1'b1;
            m_rr  = (g + 1) % NREQ;
            m_ma  = bus.req_a[32*g +: 32];
            m_mb  = bus.req_b[32*g +: 32];
            o.due = cyc + LAT + 1;
            o.idx = g;
            o.d   = fmul(m_ma, m_mb);
            pend.push_back(o);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [NREQ-1:0] rv, input logic [1:0] rv2);
        rst_n = 1'b0;
        bus.req_valid = rv;  bus.rsp_ready = '0;  bus.req_a = '0;  bus.req_b = '0;
        bus2.req_valid = rv2; bus2.rsp_ready = '0; bus2.req_a = '0; bus2.req_b = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1; bus.rsp_ready = '1; bus.req_a = {NREQ{32'h4040_0000}}; bus.req_b = {NREQ{32'h4000_0000}};
        bus2.req_valid = '1; bus2.rsp_ready = '1; bus2.req_a = '1; bus2.req_b = '1;
        model_clear();
        @(negedge clk);
        #1;
        total++; if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
        total++; if (bus.mul_valid !== 1'b0) begin bad++; $display("FAIL reset_mul_valid got=%b want=0", bus.mul_valid); end
        total++; if (bus.mul_a !== 32'h0 || bus.mul_b !== 32'h0) begin bad++; $display("FAIL reset_mul_ab got=%h/%h want=0/0", bus.mul_a, bus.mul_b); end
        total++; if (bus.rsp_valid !== 4'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0000", bus.rsp_valid); end
        total++; if (bus.rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", bus.rsp_data); end
        total++; if (bus2.req_ready !== 2'b0) begin bad++; $display("FAIL reset_req_ready2 got=%b want=00", bus2.req_ready); end
    endtask

    task automatic test_single();
        do_reset('0, '0);
        bus.req_a[31:0] = 32'h4000_0000; bus.req_b[31:0] = 32'h4040_0000; bus.req_valid = 4'b0001;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", bus.req_ready); end
        tick();
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
        #1;
        total++; if (bus.mul_valid !== 1'b1) begin bad++; $display("FAIL single_issue got=%b want=1", bus.mul_valid); end
        total++; if (bus.mul_a !== 32'h4000_0000 || bus.mul_b !== 32'h4040_0000) begin bad++; $display("FAIL single_operands got=%h/%h want=40000000/40400000", bus.mul_a, bus.mul_b); end
        for (int c = 0; c < LAT; c++) begin
            tick();
            #1;
            total++; if (bus.rsp_valid !== 4'b0) begin bad++; $display("FAIL single_early_rsp cycle=%0d got=%b want=0000", c + 2, bus.rsp_valid); end
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            total++; if (bus.rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_rsp_valid hold=%0d got=%b want=0001", c, bus.rsp_valid); end
            total++; if (bus.rsp_data[31:0] !== 32'h40C0_0000) begin bad++; $display("FAIL single_rsp_data got=%h want=40c00000", bus.rsp_data[31:0]); end
        end
        bus.rsp_ready = 4'b0001;
        tick();
        bus.rsp_ready = '0;
        #1;
        total++; if (bus.rsp_valid !== 4'b0) begin bad++; $display("FAIL single_accept got=%b want=0000", bus.rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [31:0] a [NREQ];
        logic [31:0] b [NREQ];
        do_reset('1, '0);
        for (int i = 0; i < NREQ; i++) begin
            a[i] = $urandom; b[i] = $urandom;
            bus.req_a[32*i +: 32] = a[i]; bus.req_b[32*i +: 32] = b[i];
        end
        for (int i = 0; i < NREQ; i++) begin
            #1;
            total++; if (bus.req_ready !== NREQ'(1) << i) begin bad++; $display("FAIL rr_grant step=%0d got=%b want=%b", i, bus.req_ready, NREQ'(1) << i); end
            if (i > 0) begin
                total++; if (bus.mul_valid !== 1'b1 || bus.mul_a !== a[i-1]) begin bad++; $display("FAIL rr_issue step=%0d got=%b/%h want=1/%h", i, bus.mul_valid, bus.mul_a, a[i-1]); end
            end
            tick();
        end
        #1;
        total++; if (bus.mul_valid !== 1'b1 || bus.mul_a !== a[NREQ-1] || bus.mul_b !== b[NREQ-1]) begin bad++; $display("FAIL rr_issue_last got=%b/%h/%h want=1/%h/%h", bus.mul_valid, bus.mul_a, bus.mul_b, a[NREQ-1], b[NREQ-1]); end
        total++; if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL rr_all_busy got=%b want=0000", bus.req_ready); end
        repeat (LAT + 1) tick();
        #1;
        total++; if (bus.rsp_valid !== 4'b1111) begin bad++; $display("FAIL rr_rsp_valid got=%b want=1111", bus.rsp_valid); end
        for (int i = 0; i < NREQ; i++) begin
            total++; if (bus.rsp_data[32*i +: 32] !== fmul(a[i], b[i])) begin bad++; $display("FAIL rr_rsp_data idx=%0d got=%h want=%h", i, bus.rsp_data[32*i +: 32], fmul(a[i], b[i])); end
        end
        bus.req_valid = '0; bus.rsp_ready = '1;
        tick();
        bus.rsp_ready = '0;
        #1;
        total++; if (bus.rsp_valid !== 4'b0) begin bad++; $display("FAIL rr_accept got=%b want=0000", bus.rsp_valid); end
    endtask

    task automatic test_busy_block();
        do_reset('0, '0);
        for (int i = 0; i < NREQ; i++) begin bus.req_a[32*i +: 32] = $urandom; bus.req_b[32*i +: 32] = $urandom; end
        bus.req_valid = 4'b0010;
        #1;
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL busy_first_grant got=%b want=0010", bus.req_ready); end
        tick();
        for (int c = 0; c < 20; c++) begin
            bus.req_valid = (c == 5) ? 4'b0011 : (c == 9) ? 4'b1010 : 4'b0010;
            #1;
            total++; if (bus.req_ready[1] !== 1'b0) begin bad++; $display("FAIL busy_regrant cycle=%0d got=%b want=0", c, bus.req_ready[1]); end
            if (c == 5) begin
                total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL busy_other0 got=%b want=0001", bus.req_ready); end
            end
            if (c == 9) begin
                total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL busy_other3 got=%b want=1000", bus.req_ready); end
            end
            tick();
        end
        bus.req_valid = 4'b0010; bus.rsp_ready = 4'b0010;
        #1;
        total++; if (bus.rsp_valid[1] !== 1'b1 || bus.req_ready !== 4'b0) begin bad++; $display("FAIL busy_accept_cycle got=%b/%b want=1/0000", bus.rsp_valid[1], bus.req_ready); end
        tick();
        bus.rsp_ready = '0;
        #1;
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL busy_regrant_after got=%b want=0010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
    endtask

    task automatic test_fairness();
        int last = -1, n0 = 0, n2 = 0, g;
        do_reset('0, '0);
        for (int i = 0; i < NREQ; i++) begin bus.req_a[32*i +: 32] = $urandom; bus.req_b[32*i +: 32] = $urandom; end
        bus.req_valid = 4'b0101; bus.rsp_ready = '1;
        for (int c = 0; c < 60; c++) begin
            #1;
            total++; if (bus.req_ready !== exp_ready()) begin bad++; $display("FAIL fair_grant cycle=%0d got=%b want=%b", c, bus.req_ready, exp_ready()); end
            g = (bus.req_ready === 4'b0001) ? 0 : (bus.req_ready === 4'b0100) ? 2 : -1;
            if (g >= 0) begin
                if (last >= 0) begin
                    total++; if (g == last) begin bad++; $display("FAIL fair_alternate cycle=%0d got=%0d want=%0d", c, g, 2 - last); end
                end
                last = g;
                if (g == 0) n0++; else n2++;
            end
            tick();
        end
        total++; if (n0 < 5 || n2 < 5) begin bad++; $display("FAIL fair_starve got=%0d/%0d want>=5/5", n0, n2); end
        bus.req_valid = '0; bus.rsp_ready = '0;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] a, b;
        do_reset('1, '0);
        for (int i = 0; i < NREQ; i++) begin bus.req_a[32*i +: 32] = $urandom; bus.req_b[32*i +: 32] = $urandom; end
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0 || bus.mul_valid !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got=%b/%b want=0000/0", bus.req_ready, bus.mul_valid); end
        total++; if (bus.mul_a !== 32'h0 || bus.mul_b !== 32'h0) begin bad++; $display("FAIL midrst_mul_ab got=%h/%h want=0/0", bus.mul_a, bus.mul_b); end
        total++; if (bus.rsp_valid !== 4'b0 || bus.rsp_data !== '0) begin bad++; $display("FAIL midrst_rsp got=%b/%h want=0000/0", bus.rsp_valid, bus.rsp_data); end
        model_clear();
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < LAT + 6; c++) begin
            #1;
            total++; if (bus.rsp_valid !== 4'b0 || bus.mul_valid !== 1'b0) begin bad++; $display("FAIL midrst_ghost cycle=%0d got=%b/%b want=0000/0", c, bus.rsp_valid, bus.mul_valid); end
            tick();
        end
        a = $urandom; b = $urandom;
        bus.req_a[64 +: 32] = a; bus.req_b[64 +: 32] = b; bus.req_valid = 4'b0100;
        #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL midrst_new_grant got=%b want=0100", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        repeat (LAT + 1) tick();
        #1;
        total++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_data[64 +: 32] !== fmul(a, b)) begin bad++; $display("FAIL midrst_new_rsp got=%b/%h want=0100/%h", bus.rsp_valid, bus.rsp_data[64 +: 32], fmul(a, b)); end
    endtask

    task automatic test_random();
        do_reset('0, '0);
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = NREQ'($urandom);
            bus.rsp_ready = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin bus.req_a[32*i +: 32] = $urandom; bus.req_b[32*i +: 32] = $urandom; end
            #1;
            total++; if (bus.req_ready !== exp_ready()) begin bad++; $display("FAIL rnd_grant cycle=%0d got=%b want=%b", c, bus.req_ready, exp_ready()); end
            total++; if (bus.mul_valid !== m_mv || bus.mul_a !== m_ma || bus.mul_b !== m_mb) begin bad++; $display("FAIL rnd_issue cycle=%0d got=%b/%h/%h want=%b/%h/%h", c, bus.mul_valid, bus.mul_a, bus.mul_b, m_mv, m_ma, m_mb); end
            total++; if (bus.rsp_valid !== m_rv) begin bad++; $display("FAIL rnd_rsp_valid cycle=%0d got=%b want=%b", c, bus.rsp_valid, m_rv); end
            total++; if (bus.rsp_data !== exp_data()) begin bad++; $display("FAIL rnd_rsp_data cycle=%0d got=%h want=%h", c, bus.rsp_data, exp_data()); end
            tick();
        end
        bus.req_valid = '0; bus.rsp_ready = '0;
    endtask

    task automatic test_small_params();
        logic [31:0] a0, b0, a1, b1;
        do_reset('0, '0);
        bus2.req_a = {32'h0, 32'h4000_0000}; bus2.req_b = {32'h0, 32'h4040_0000}; bus2.req_valid = 2'b01;
        #1;
        total++; if (bus2.req_ready !== 2'b01) begin bad++; $display("FAIL small_grant got=%b want=01", bus2.req_ready); end
        tick();
        bus2.req_valid = '0;
        #1;
        total++; if (bus2.mul_valid !== 1'b1 || bus2.rsp_valid !== 2'b0) begin bad++; $display("FAIL small_issue got=%b/%b want=1/00", bus2.mul_valid, bus2.rsp_valid); end
        tick();
        #1;
        total++; if (bus2.rsp_valid !== 2'b0) begin bad++; $display("FAIL small_early_rsp got=%b want=00", bus2.rsp_valid); end
        tick();
        #1;
        total++; if (bus2.rsp_valid !== 2'b01 || bus2.rsp_data[31:0] !== 32'h40C0_0000) begin bad++; $display("FAIL small_rsp got=%b/%h want=01/40c00000", bus2.rsp_valid, bus2.rsp_data[31:0]); end
        do_reset('0, 2'b11);
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        bus2.req_a = {a1, a0}; bus2.req_b = {b1, b0};
        #1;
        total++; if (bus2.req_ready !== 2'b01) begin bad++; $display("FAIL small_rr0 got=%b want=01", bus2.req_ready); end
        tick();
        #1;
        total++; if (bus2.req_ready !== 2'b10 || bus2.mul_a !== a0) begin bad++; $display("FAIL small_rr1 got=%b/%h want=10/%h", bus2.req_ready, bus2.mul_a, a0); end
        tick();
        #1;
        total++; if (bus2.req_ready !== 2'b00 || bus2.mul_b !== b1) begin bad++; $display("FAIL small_rr_busy got=%b/%h want=00/%h", bus2.req_ready, bus2.mul_b, b1); end
        tick();
        tick();
        #1;
        total++; if (bus2.rsp_valid !== 2'b11 || bus2.rsp_data !== {fmul(a1, b1), fmul(a0, b0)}) begin bad++; $display("FAIL small_rr_rsp got=%b/%h want=11/%h", bus2.rsp_valid, bus2.rsp_data, {fmul(a1, b1), fmul(a0, b0)}); end
        bus2.req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy_block();
        test_fairness();
        test_reset_midflight();
        test_random();
        test_small_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
